// File: rtl/fill_acquisition_ctrl.sv
// -----------------------------------------------------------------------------
// fill_acquisition_ctrl
//
// Purpose:
//   Responder side of the trigger go/done handshake. On go it latches the fill
//   number, writes a fixed-length burst of ADC samples into an external fill
//   buffer (one write per accepted sample, one clock after the sample), then
//   holds done until go is released. Also reports fill-number sequence errors
//   (sticky) and aborts (go released before the fill completed).
//
// Optional feature macro: FILL_HEADER_EN
//   When defined, a one-cycle HDR state writes {zeros, fill_tag} to address 0
//   and samples land at addresses 1..FILL_LEN. When undefined, samples land at
//   addresses 0..FILL_LEN-1 and HDR does not exist.
//
// Parameters:
//   DATA_W   width of sample_data / wr_data (>= 8)
//   ADDR_W   width of wr_addr
//   FILL_LEN samples per fill (1..2**ADDR_W, or 1..2**ADDR_W-1 with header)
//
// Ports:
//   clk           in   system clock, rising edge
//   reset         in   asynchronous active-low reset
//   go            in   fill request level, held until done is seen
//   fillNum       in   8-bit fill number, valid while go is high
//   sample_valid  in   sample_data qualifier
//   sample_data   in   ADC sample
//   wr_en         out  buffer write strobe (registered)
//   wr_addr       out  buffer write address (registered)
//   wr_data       out  buffer write data (registered)
//   done          out  fill complete, held until go falls
//   busy          out  high in every state except IDLE
//   fill_tag      out  fill number of the current/last fill
//   seq_err       out  sticky: fillNum was not last fill + 1 (mod 256)
//   abort         out  one-cycle pulse: go fell before the fill completed
// -----------------------------------------------------------------------------
module fill_acquisition_ctrl #(
    parameter int DATA_W   = 16,
    parameter int ADDR_W   = 10,
    parameter int FILL_LEN = 512
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     go,
    input  logic [7:0]               fillNum,
    input  logic                     sample_valid,
    input  logic signed [DATA_W-1:0] sample_data,
    output logic                     wr_en,
    output logic [ADDR_W-1:0]        wr_addr,
    output logic signed [DATA_W-1:0] wr_data,
    output logic                     done,
    output logic                     busy,
    output logic [7:0]               fill_tag,
    output logic                     seq_err,
    output logic                     abort
);

`ifdef FILL_HEADER_EN
    typedef enum logic [1:0] {IDLE, HDR, ACQ, DONE} state_t;
    localparam int ADDR_OFF = 1;
`else
    typedef enum logic [1:0] {IDLE, ACQ, DONE} state_t;
    localparam int ADDR_OFF = 0;
`endif

    localparam logic [ADDR_W-1:0] LAST_CNT = ADDR_W'(FILL_LEN - 1);
    localparam logic [ADDR_W-1:0] OFF_ADDR = ADDR_W'(ADDR_OFF);

`ifdef FILL_HEADER_EN
    // Header word: fill number in the low byte, upper bits zero.
    function automatic logic signed [DATA_W-1:0] header_word(input logic [7:0] tag);
        logic [DATA_W-1:0] w;
        w      = '0;
        w[7:0] = tag;
        return $signed(w);
    endfunction
`endif

    state_t                   r_state;
    state_t                   w_state_nxt;
    logic [ADDR_W-1:0]        r_count;
    logic [7:0]               r_last_fill;
    logic [7:0]               r_fill_tag;
    logic                     r_seq_err;
    logic                     r_abort;
    logic                     r_vld_p1;
    logic [ADDR_W-1:0]        r_addr_p1;
    logic signed [DATA_W-1:0] r_data_p1;

    logic w_start;
    logic w_accept;
    logic w_last;
    logic w_abort;
    logic w_hdr_wr;

    assign w_start  = (r_state == IDLE) && go;
    assign w_accept = (r_state == ACQ) && go && sample_valid;
    assign w_last   = w_accept && (r_count == LAST_CNT);
`ifdef FILL_HEADER_EN
    assign w_hdr_wr = (r_state == HDR) && go;
    assign w_abort  = ((r_state == HDR) || (r_state == ACQ)) && !go;
`else
    assign w_hdr_wr = 1'b0;
    assign w_abort  = (r_state == ACQ) && !go;
`endif

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; go low in HDR/ACQ aborts, go low in DONE completes the handshake
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (go) begin
`ifdef FILL_HEADER_EN
                    w_state_nxt = HDR;
`else
                    w_state_nxt = ACQ;
`endif
                end
            end
`ifdef FILL_HEADER_EN
            HDR: begin
                if (!go) w_state_nxt = IDLE;
                else     w_state_nxt = ACQ;
            end
`endif
            ACQ: begin
                if (!go)         w_state_nxt = IDLE;
                else if (w_last) w_state_nxt = DONE;
            end
            DONE: begin
                if (!go) w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Fill bookkeeping: tag, sequence check and sample counter
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_fill_tag  <= '0;
            r_last_fill <= '0;
            r_seq_err   <= 1'b0;
            r_count     <= '0;
            r_abort     <= 1'b0;
        end else begin
            r_abort <= w_abort;
            if (w_start) begin
                r_fill_tag  <= fillNum;
                r_last_fill <= fillNum;
                r_seq_err   <= r_seq_err | (fillNum != (r_last_fill + 8'd1));
                r_count     <= '0;
            end else if (w_accept) begin
                // Wraps only past the final sample, where the fill is already over.
                r_count <= r_count + 1'b1;
            end
        end
    end

    // Write stage p1: one clock from accepted sample to buffer write
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_vld_p1  <= 1'b0;
            r_addr_p1 <= '0;
            r_data_p1 <= '0;
        end else begin
            r_vld_p1 <= w_accept | w_hdr_wr;
            if (w_accept) begin
                r_addr_p1 <= r_count + OFF_ADDR;
                r_data_p1 <= sample_data;
            end
`ifdef FILL_HEADER_EN
            else if (w_hdr_wr) begin
                r_addr_p1 <= '0;
                r_data_p1 <= header_word(r_fill_tag);
            end
`endif
        end
    end

    assign wr_en    = r_vld_p1;
    assign wr_addr  = r_addr_p1;
    assign wr_data  = r_data_p1;
    assign done     = (r_state == DONE);
    assign busy     = (r_state != IDLE);
    assign fill_tag = r_fill_tag;
    assign seq_err  = r_seq_err;
    assign abort    = r_abort;

endmodule

// File: tb/tb_fill_acquisition_ctrl.sv
// -----------------------------------------------------------------------------
// tb_fill_acquisition_ctrl
//
// Directed bench for fill_acquisition_ctrl with FILL_LEN=4. Inputs are driven
// and outputs sampled on the falling clock edge. Builds with or without
// FILL_HEADER_EN; address expectations shift by one when the header is on.
// -----------------------------------------------------------------------------
module tb_fill_acquisition_ctrl;

    localparam int DW   = 16;
    localparam int AW   = 10;
    localparam int FLEN = 4;
`ifdef FILL_HEADER_EN
    localparam int HOFF = 1;
`else
    localparam int HOFF = 0;
`endif

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 go;
    logic [7:0]           fillNum;
    logic                 sample_valid;
    logic signed [DW-1:0] sample_data;
    logic                 wr_en;
    logic [AW-1:0]        wr_addr;
    logic signed [DW-1:0] wr_data;
    logic                 done;
    logic                 busy;
    logic [7:0]           fill_tag;
    logic                 seq_err;
    logic                 abort;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fill_acquisition_ctrl #(
        .DATA_W  (DW),
        .ADDR_W  (AW),
        .FILL_LEN(FLEN)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .go          (go),
        .fillNum     (fillNum),
        .sample_valid(sample_valid),
        .sample_data (sample_data),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .done        (done),
        .busy        (busy),
        .fill_tag    (fill_tag),
        .seq_err     (seq_err),
        .abort       (abort)
    );

    // Raise go with fill number n; returns at the falling edge after the
    // header write (header build) or after go was accepted (no header).
    task automatic start_fill(input logic [7:0] n);
        @(negedge clk);
        go           = 1'b1;
        fillNum      = n;
        sample_valid = 1'b0;
        @(negedge clk);
`ifdef FILL_HEADER_EN
        @(negedge clk);
`endif
    endtask

    task automatic test_reset();
        reset = 1'b0; go = 1'b0; fillNum = 8'd0; sample_valid = 1'b0; sample_data = '0;
        repeat (2) @(negedge clk);
        checks++; if (wr_en !== 1'b0)    begin errors++; $display("FAIL reset_wr_en got %b want 0", wr_en); end
        checks++; if (wr_addr !== '0)    begin errors++; $display("FAIL reset_wr_addr got %0d want 0", wr_addr); end
        checks++; if (wr_data !== '0)    begin errors++; $display("FAIL reset_wr_data got %h want 0", wr_data); end
        checks++; if (done !== 1'b0)     begin errors++; $display("FAIL reset_done got %b want 0", done); end
        checks++; if (busy !== 1'b0)     begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        checks++; if (fill_tag !== 8'd0) begin errors++; $display("FAIL reset_fill_tag got %h want 0", fill_tag); end
        checks++; if (seq_err !== 1'b0)  begin errors++; $display("FAIL reset_seq_err got %b want 0", seq_err); end
        checks++; if (abort !== 1'b0)    begin errors++; $display("FAIL reset_abort got %b want 0", abort); end
        reset = 1'b1;
    endtask

    task automatic test_basic();
        logic exp_done;
        start_fill(8'd1);
        checks++; if (busy !== 1'b1)     begin errors++; $display("FAIL basic_busy got %b want 1", busy); end
        checks++; if (fill_tag !== 8'd1) begin errors++; $display("FAIL basic_fill_tag got %h want 01", fill_tag); end
`ifndef FILL_HEADER_EN
        checks++; if (wr_en !== 1'b0)    begin errors++; $display("FAIL basic_idle_wr_en got %b want 0", wr_en); end
`endif
        for (int i = 0; i < FLEN; i++) begin
            sample_valid = 1'b1;
            sample_data  = DW'(16'h00A0 + i);
            @(negedge clk);
            exp_done = (i == FLEN - 1);
            checks++; if (wr_en !== 1'b1) begin errors++; $display("FAIL basic_wr_en[%0d] got %b want 1", i, wr_en); end
            checks++; if (wr_addr !== AW'(i + HOFF)) begin errors++; $display("FAIL basic_wr_addr[%0d] got %0d want %0d", i, wr_addr, i + HOFF); end
            checks++; if (wr_data !== DW'(16'h00A0 + i)) begin errors++; $display("FAIL basic_wr_data[%0d] got %h want %h", i, wr_data, 16'h00A0 + i); end
            checks++; if (done !== exp_done) begin errors++; $display("FAIL basic_done[%0d] got %b want %b", i, done, exp_done); end
        end
        checks++; if (seq_err !== 1'b0) begin errors++; $display("FAIL basic_seq_err got %b want 0", seq_err); end
        // Samples offered in DONE must not be written
        sample_data = DW'(16'h00FF);
        @(negedge clk);
        checks++; if (wr_en !== 1'b0) begin errors++; $display("FAIL basic_done_ignore_wr_en got %b want 0", wr_en); end
        checks++; if (done !== 1'b1)  begin errors++; $display("FAIL basic_done_hold got %b want 1", done); end
        sample_valid = 1'b0;
        go = 1'b0;
        @(negedge clk);
        checks++; if (done !== 1'b0)  begin errors++; $display("FAIL basic_release_done got %b want 0", done); end
        checks++; if (busy !== 1'b0)  begin errors++; $display("FAIL basic_release_busy got %b want 0", busy); end
        checks++; if (abort !== 1'b0) begin errors++; $display("FAIL basic_release_abort got %b want 0", abort); end
    endtask

    task automatic test_gapped();
        logic [6:0] pat;
        int cnt;
        logic exp_done;
        pat = 7'b1011001;  // applied LSB first: 1,0,0,1,1,0,1
        cnt = 0;
        start_fill(8'd2);
        for (int k = 0; k < 7; k++) begin
            sample_valid = pat[k];
            sample_data  = DW'(16'h00B0 + k);
            @(negedge clk);
            if (pat[k]) begin
                checks++; if (wr_en !== 1'b1) begin errors++; $display("FAIL gap_wr_en[%0d] got %b want 1", k, wr_en); end
                checks++; if (wr_addr !== AW'(cnt + HOFF)) begin errors++; $display("FAIL gap_wr_addr[%0d] got %0d want %0d", k, wr_addr, cnt + HOFF); end
                checks++; if (wr_data !== DW'(16'h00B0 + k)) begin errors++; $display("FAIL gap_wr_data[%0d] got %h want %h", k, wr_data, 16'h00B0 + k); end
                cnt++;
            end else begin
                checks++; if (wr_en !== 1'b0) begin errors++; $display("FAIL gap_idle_wr_en[%0d] got %b want 0", k, wr_en); end
            end
            exp_done = (cnt == FLEN);
            checks++; if (done !== exp_done) begin errors++; $display("FAIL gap_done[%0d] got %b want %b", k, done, exp_done); end
        end
        checks++; if (seq_err !== 1'b0) begin errors++; $display("FAIL gap_seq_err got %b want 0", seq_err); end
        sample_valid = 1'b0;
        go = 1'b0;
        @(negedge clk);
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL gap_release_done got %b want 0", done); end
    endtask

    task automatic test_seq_err();
        start_fill(8'd4);
        checks++; if (seq_err !== 1'b1) begin errors++; $display("FAIL seq_set got %b want 1", seq_err); end
        checks++; if (fill_tag !== 8'd4) begin errors++; $display("FAIL seq_fill_tag got %h want 04", fill_tag); end
        sample_valid = 1'b1;
        repeat (FLEN) @(negedge clk);
        sample_valid = 1'b0;
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL seq_done got %b want 1", done); end
        go = 1'b0;
        @(negedge clk);
        start_fill(8'd5);
        checks++; if (seq_err !== 1'b1) begin errors++; $display("FAIL seq_sticky got %b want 1", seq_err); end
        sample_valid = 1'b1;
        repeat (FLEN) @(negedge clk);
        sample_valid = 1'b0;
        go = 1'b0;
        @(negedge clk);
        checks++; if (seq_err !== 1'b1) begin errors++; $display("FAIL seq_sticky_end got %b want 1", seq_err); end
    endtask

    task automatic test_abort();
        logic exp_done;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        start_fill(8'd1);
        for (int i = 0; i < 2; i++) begin
            sample_valid = 1'b1;
            sample_data  = DW'(16'h00C0 + i);
            @(negedge clk);
            checks++; if (wr_addr !== AW'(i + HOFF)) begin errors++; $display("FAIL abort_pre_addr[%0d] got %0d want %0d", i, wr_addr, i + HOFF); end
        end
        go = 1'b0;
        sample_data = DW'(16'h00C2);
        @(negedge clk);
        checks++; if (abort !== 1'b1)    begin errors++; $display("FAIL abort_pulse got %b want 1", abort); end
        checks++; if (wr_en !== 1'b0)    begin errors++; $display("FAIL abort_wr_en got %b want 0", wr_en); end
        checks++; if (done !== 1'b0)     begin errors++; $display("FAIL abort_done got %b want 0", done); end
        checks++; if (busy !== 1'b0)     begin errors++; $display("FAIL abort_busy got %b want 0", busy); end
        checks++; if (fill_tag !== 8'd1) begin errors++; $display("FAIL abort_fill_tag got %h want 01", fill_tag); end
        @(negedge clk);
        checks++; if (abort !== 1'b0) begin errors++; $display("FAIL abort_one_cycle got %b want 0", abort); end
        checks++; if (wr_en !== 1'b0) begin errors++; $display("FAIL abort_after_wr_en got %b want 0", wr_en); end
        sample_valid = 1'b0;
        start_fill(8'd2);
        checks++; if (seq_err !== 1'b0) begin errors++; $display("FAIL abort_next_seq_err got %b want 0", seq_err); end
        for (int i = 0; i < FLEN; i++) begin
            sample_valid = 1'b1;
            sample_data  = DW'(16'h00D0 + i);
            @(negedge clk);
            exp_done = (i == FLEN - 1);
            checks++; if (wr_addr !== AW'(i + HOFF)) begin errors++; $display("FAIL abort_next_addr[%0d] got %0d want %0d", i, wr_addr, i + HOFF); end
            checks++; if (wr_data !== DW'(16'h00D0 + i)) begin errors++; $display("FAIL abort_next_data[%0d] got %h want %h", i, wr_data, 16'h00D0 + i); end
            checks++; if (done !== exp_done) begin errors++; $display("FAIL abort_next_done[%0d] got %b want %b", i, done, exp_done); end
        end
        sample_valid = 1'b0;
        go = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_async_reset();
        start_fill(8'd7);
        checks++; if (seq_err !== 1'b1) begin errors++; $display("FAIL areset_pre_seq_err got %b want 1", seq_err); end
        sample_valid = 1'b1;
        repeat (2) @(negedge clk);
        #2;
        reset = 1'b0;
        #1;
        checks++; if (wr_en !== 1'b0)    begin errors++; $display("FAIL areset_wr_en got %b want 0", wr_en); end
        checks++; if (busy !== 1'b0)     begin errors++; $display("FAIL areset_busy got %b want 0", busy); end
        checks++; if (done !== 1'b0)     begin errors++; $display("FAIL areset_done got %b want 0", done); end
        checks++; if (fill_tag !== 8'd0) begin errors++; $display("FAIL areset_fill_tag got %h want 0", fill_tag); end
        checks++; if (seq_err !== 1'b0)  begin errors++; $display("FAIL areset_seq_err got %b want 0", seq_err); end
        go = 1'b0;
        sample_valid = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        start_fill(8'd1);
        checks++; if (seq_err !== 1'b0) begin errors++; $display("FAIL areset_first_seq_err got %b want 0", seq_err); end
        sample_valid = 1'b1;
        repeat (FLEN) @(negedge clk);
        sample_valid = 1'b0;
        checks++; if (done !== 1'b1)    begin errors++; $display("FAIL areset_fill_done got %b want 1", done); end
        checks++; if (wr_addr !== AW'(FLEN - 1 + HOFF)) begin errors++; $display("FAIL areset_last_addr got %0d want %0d", wr_addr, FLEN - 1 + HOFF); end
        go = 1'b0;
        @(negedge clk);
    endtask

`ifdef FILL_HEADER_EN
    task automatic test_header();
        logic exp_done;
        @(negedge clk);
        go = 1'b1;
        fillNum = 8'h05;
        sample_valid = 1'b1;
        sample_data = DW'(16'h1111);
        @(negedge clk);
        checks++; if (busy !== 1'b1)      begin errors++; $display("FAIL hdr_busy got %b want 1", busy); end
        checks++; if (wr_en !== 1'b0)     begin errors++; $display("FAIL hdr_pre_wr_en got %b want 0", wr_en); end
        checks++; if (fill_tag !== 8'h05) begin errors++; $display("FAIL hdr_fill_tag got %h want 05", fill_tag); end
        @(negedge clk);
        checks++; if (wr_en !== 1'b1)        begin errors++; $display("FAIL hdr_wr_en got %b want 1", wr_en); end
        checks++; if (wr_addr !== '0)        begin errors++; $display("FAIL hdr_wr_addr got %0d want 0", wr_addr); end
        checks++; if (wr_data !== DW'(16'h0005)) begin errors++; $display("FAIL hdr_wr_data got %h want 0005", wr_data); end
        for (int i = 0; i < FLEN; i++) begin
            sample_data = DW'(16'h00E0 + i);
            @(negedge clk);
            exp_done = (i == FLEN - 1);
            checks++; if (wr_addr !== AW'(i + 1)) begin errors++; $display("FAIL hdr_addr[%0d] got %0d want %0d", i, wr_addr, i + 1); end
            checks++; if (wr_data !== DW'(16'h00E0 + i)) begin errors++; $display("FAIL hdr_data[%0d] got %h want %h", i, wr_data, 16'h00E0 + i); end
            checks++; if (done !== exp_done) begin errors++; $display("FAIL hdr_done[%0d] got %b want %b", i, done, exp_done); end
        end
        sample_valid = 1'b0;
        go = 1'b0;
        @(negedge clk);
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_gapped();
        test_seq_err();
        test_abort();
        test_async_reset();
`ifdef FILL_HEADER_EN
        test_header();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fill_acquisition_ctrl.md
Name: fill_acquisition_ctrl

Overview:
Responder side of the trigger go/done handshake. It waits for go from the trigger manager and latches the 8-bit fill number. It then writes a fixed-length burst of ADC samples into an external fill buffer and raises done until go is released. It sits between the trigger manager and the per-channel sample buffer, and also reports fill-number sequence and abort errors.

Parameters:
DATA_W, 16, width of sample_data and wr_data (must be >= 8).
ADDR_W, 10, width of wr_addr.
FILL_LEN, 512, samples written per fill. Legal range is 1 .. 2**ADDR_W, or 1 .. 2**ADDR_W-1 when FILL_HEADER_EN is defined.

Ports:
clk  in  1  system clock; all logic on its rising edge
reset  in  1  asynchronous, active-low reset
go  in  1  fill request level from the trigger manager; held high until done is seen
fillNum  in  8  fill number; valid while go is high
sample_valid  in  1  sample_data qualifier
sample_data  in  DATA_W  ADC sample
wr_en  out  1  buffer write strobe (registered)
wr_addr  out  ADDR_W  buffer write address (registered)
wr_data  out  DATA_W  buffer write data (registered)
done  out  1  fill complete; held until go falls
busy  out  1  high in every state except IDLE
fill_tag  out  8  fill number latched at start of current/last fill
seq_err  out  1  sticky: fillNum was not last fill + 1 (mod 256)
abort  out  1  one-cycle pulse: go fell before the fill completed

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE; all outputs 0; internal last_fill=0; sample counter=0.
- States: IDLE, HDR (only when FILL_HEADER_EN is defined), ACQ, DONE.
- IDLE, go=1:
  - fill_tag<=fillNum.
  - seq_err<=seq_err | (fillNum != last_fill+1 mod 256).
  - last_fill<=fillNum; count<=0.
  - Next state is HDR if FILL_HEADER_EN is defined, else ACQ.
  - The first fill after reset expects fillNum=1.
- ACQ: each cycle with sample_valid=1, the next cycle shows:
  - wr_en=1, wr_data=sample_data, wr_addr=count (+1 offset when the header is enabled).
  - count then increments.
  - Latency is exactly 1 clk from sample to write.
  - sample_valid=0 gives wr_en=0 and count holds.
- ACQ completion: the accepted sample with count==FILL_LEN-1 moves the state to DONE. done=1 from the cycle that shows the final write.
- DONE:
  - done held 1 while go=1.
  - When go=0 is sampled: done<=0, state<=IDLE.
  - A new fill cannot start until go has been seen low.
- Abort: go=0 sampled in HDR or ACQ →
  - abort pulses 1 for one cycle and state<=IDLE.
  - No further writes; a write already registered for the current sample still completes.
  - done is never asserted; fill_tag and last_fill keep the aborted fill's number.
- Inputs outside ACQ: sample_valid is ignored in IDLE, HDR and DONE.
- Address rules:
  - wr_addr never exceeds FILL_LEN-1 (FILL_LEN with header); no wrap within a fill.
  - Every fill restarts at address 0.
- seq_err is cleared only by reset.
- Reset mid-fill: immediate return to IDLE; done, wr_en and busy drop asynchronously.

Optional Feature:
Macro FILL_HEADER_EN.
- Defined:
  - The cycle after go is accepted, state HDR issues one write: wr_en=1, wr_addr=0, wr_data={zeros, fill_tag}.
  - Samples then go to addresses 1..FILL_LEN, for FILL_LEN+1 writes total.
  - HDR lasts exactly one cycle, then ACQ.
- Undefined: HDR does not exist; samples go to addresses 0..FILL_LEN-1.

Test Plan:
- Basic fill, FILL_LEN=4, no header:
  - Stimulus: reset, go=1 with fillNum=1, sample_valid continuous with data 0xA0..0xA3.
  - Response: writes addr 0..3, data A0..A3, each 1 cycle after its sample; done=1 from the addr-3 write; seq_err=0.
  - Then go=0 → done=0 next cycle, busy=0.
- Gapped samples:
  - Stimulus: sample_valid pattern 1,0,0,1,1,0,1.
  - Response: exactly 4 writes at addresses 0..3, no wr_en in the gap cycles, done after the 4th.
- Sequence error:
  - Stimulus: fills with fillNum 1, then 2, then 4.
  - Response: seq_err=0 after the second fill; seq_err=1 from the cycle after go is accepted for fill 4 and stays 1 through later fills.
- Abort:
  - Stimulus: go drops after 2 of 4 samples.
  - Response: abort pulses for exactly one cycle, no done, no further writes.
  - Then a next go with fillNum=fill_tag+1 gives seq_err=0 and a clean fill from addr 0.
- Header (FILL_HEADER_EN), FILL_LEN=3, fillNum=0x05:
  - Response: writes (0,0x0005), then samples at 1..3; 4 writes total; done after addr 3.
- Async reset mid-ACQ:
  - Stimulus: assert reset between clock edges.
  - Response: wr_en, busy, done, fill_tag, seq_err all 0 immediately.
  - After release, the first fill must carry fillNum=1 for seq_err to stay 0.
